// File: rtl/main_control_fsm.sv
// ---------------------------------------------------------------------------
// main_control_fsm
// Multi-cycle main control unit. Decodes the instruction opcode held in the
// instruction register and steps the datapath through one state per clock.
// Outputs are a Moore decode of the state register. The exceptions are the
// fetch strobes irWrite/pcWrite, which follow memReady.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   opcode      in   [5:0] instruction[31:26] from the instruction register
//   memReady    in   memory completes the current access this cycle
//   pcWrite     out  unconditional PC load
//   pcWriteCond out  PC load if ALU zero
//   iorD        out  memory address select (0 = PC, 1 = ALUOut)
//   memRead     out  memory read request
//   memWrite    out  memory write request
//   irWrite     out  instruction register load
//   memToReg    out  register write data (0 = ALUOut, 1 = MDR)
//   regDst      out  destination register (0 = rt, 1 = rd)
//   regWrite    out  register file write
//   aluSrcA     out  ALU A select (0 = PC, 1 = rs)
//   aluSrcB     out  [1:0] ALU B select (rt / 4 / imm / imm<<2)
//   aluOp       out  [1:0] to ALU_Control (00 add, 01 sub, 10 R-type)
//   pcSource    out  [1:0] PC source (ALU / ALUOut / jump target)
//   illegalOp   out  sticky flag: unsupported opcode seen in DECODE
//   state       out  [3:0] current state, for debug
// ---------------------------------------------------------------------------
module main_control_fsm #(
    parameter bit ADDI_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       iorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic       memToReg,
    output logic       regDst,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic [1:0] pcSource,
    output logic       illegalOp,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_RTYPE  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BEQ    = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t     r_state;
    state_t     w_next_state;
    logic       r_illegal;
    logic       w_illegal_set;

    logic       w_pc_write;
    logic       w_pc_write_cond;
    logic       w_iord;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_mem_to_reg;
    logic       w_reg_dst;
    logic       w_reg_write;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic [1:0] w_pc_source;

    // Next-state selection and illegal-opcode detection
    always_comb begin
        w_next_state  = S_FETCH;
        w_illegal_set = 1'b0;
        case (r_state)
            S_IDLE:   w_next_state = S_FETCH;
            S_FETCH: begin
                if (memReady) begin
                    w_next_state = S_DECODE;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE:     w_next_state = S_RTYPE;
                    OP_BEQ:       w_next_state = S_BEQ;
                    OP_J:         w_next_state = S_JUMP;
                    OP_ADDI: begin
                        if (ADDI_EN) begin
                            w_next_state = S_ADDIEX;
                        end else begin
                            w_next_state  = S_FETCH;
                            w_illegal_set = 1'b1;
                        end
                    end
                    default: begin
                        w_next_state  = S_FETCH;
                        w_illegal_set = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_LW) begin
                    w_next_state = S_MEMRD;
                end else begin
                    w_next_state = S_MEMWR;
                end
            end
            S_MEMRD: begin
                if (memReady) begin
                    w_next_state = S_MEMWB;
                end else begin
                    w_next_state = S_MEMRD;
                end
            end
            S_MEMWR: begin
                if (memReady) begin
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_MEMWR;
                end
            end
            S_RTYPE:  w_next_state = S_ALUWB;
            S_ADDIEX: w_next_state = S_ADDIWB;
            // MEMWB, ALUWB, BEQ, JUMP, ADDIWB and the unused codes 13-15
            // all return to FETCH.
            default:  w_next_state = S_FETCH;
        endcase
    end

    // State register and sticky illegal-opcode flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_illegal_set) begin
                r_illegal <= 1'b1;
            end
        end
    end

    // Control decode from the current state; only the fetch strobes see memReady
    always_comb begin
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_iord          = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_reg_dst       = 1'b0;
        w_reg_write     = 1'b0;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = 2'b00;
        w_alu_op        = 2'b00;
        w_pc_source     = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                w_ir_write  = memReady;
                w_pc_write  = memReady;
            end
            // Branch target is precomputed here while the opcode is decoded
            S_DECODE: w_alu_src_b = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                w_mem_read = 1'b1;
                w_iord     = 1'b1;
            end
            S_MEMWB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
            end
            // memWrite is held for every wait cycle until memory accepts
            S_MEMWR: begin
                w_mem_write = 1'b1;
                w_iord      = 1'b1;
            end
            S_RTYPE: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b10;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
            end
            S_BEQ: begin
                w_alu_src_a     = 1'b1;
                w_alu_op        = 2'b01;
                w_pc_write_cond = 1'b1;
                w_pc_source     = 2'b01;
            end
            S_JUMP: begin
                w_pc_write  = 1'b1;
                w_pc_source = 2'b10;
            end
            S_ADDIWB: w_reg_write = 1'b1;
            default: begin
                w_pc_write = 1'b0;
            end
        endcase
    end

    // Write strobes are additionally gated by rst_n so none can glitch
    // high while reset is being asserted.
    assign pcWrite     = w_pc_write      & rst_n;
    assign pcWriteCond = w_pc_write_cond & rst_n;
    assign memWrite    = w_mem_write     & rst_n;
    assign irWrite     = w_ir_write      & rst_n;
    assign regWrite    = w_reg_write     & rst_n;
    assign iorD        = w_iord;
    assign memRead     = w_mem_read;
    assign memToReg    = w_mem_to_reg;
    assign regDst      = w_reg_dst;
    assign aluSrcA     = w_alu_src_a;
    assign aluSrcB     = w_alu_src_b;
    assign aluOp       = w_alu_op;
    assign pcSource    = w_pc_source;
    assign illegalOp   = r_illegal;
    assign state       = r_state;

endmodule

// File: tb/tb_main_control_fsm.sv
module tb_main_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'b100011;
    logic       memReady = 1'b1;
    logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
    logic       memToReg, regDst, regWrite, aluSrcA, illegalOp;
    logic [1:0] aluSrcB, aluOp, pcSource;
    logic [3:0] state;

    main_control_fsm #(.ADDI_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .memReady(memReady),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD),
        .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
        .memToReg(memToReg), .regDst(regDst), .regWrite(regWrite),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
        .pcSource(pcSource), .illegalOp(illegalOp), .state(state)
    );

    always #5 clk = ~clk;

    // Control word: {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
    //                memToReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource}
    logic [15:0] ctl_s;
    assign ctl_s = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
                    memToReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource};

    localparam logic [15:0] C_ZERO = 16'h0000;
    localparam logic [15:0] C_F1   = 16'h9410; // pcWrite, memRead, irWrite, B=01
    localparam logic [15:0] C_F0   = 16'h1010; // memRead, B=01
    localparam logic [15:0] C_DEC  = 16'h0030; // B=11
    localparam logic [15:0] C_MA   = 16'h0060; // A=1, B=10
    localparam logic [15:0] C_MR   = 16'h3000; // iorD, memRead
    localparam logic [15:0] C_MWB  = 16'h0280; // memToReg, regWrite
    localparam logic [15:0] C_MW   = 16'h2800; // iorD, memWrite
    localparam logic [15:0] C_RT   = 16'h0048; // A=1, aluOp=10
    localparam logic [15:0] C_AWB  = 16'h0180; // regDst, regWrite
    localparam logic [15:0] C_BEQ  = 16'h4045; // pcWriteCond, A=1, aluOp=01, pcSrc=01
    localparam logic [15:0] C_J    = 16'h8002; // pcWrite, pcSrc=10
    localparam logic [15:0] C_AIWB = 16'h0080; // regWrite

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BQ = 6'b000100, JJ = 6'b000010, AI = 6'b001000;
    localparam logic [5:0] BAD = 6'b111111;

    typedef struct {
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [15:0] ctl;
        logic        ill;
    } vec_t;

    int   n_cmp = 0;
    int   n_fail = 0;
    logic m_ill = 1'b0;
    vec_t tbl[$];

    function automatic vec_t mk(logic [5:0] op, logic rdy, logic [3:0] st,
                                logic [15:0] ctl, logic ill);
        vec_t v;
        v.op = op; v.rdy = rdy; v.st = st; v.ctl = ctl; v.ill = ill;
        return v;
    endfunction

    task automatic check(input string nm, input logic [3:0] es,
                         input logic [15:0] ec, input logic ei);
        n_cmp++;
        if ({state, ctl_s, illegalOp} !== {es, ec, ei}) begin
            n_fail++;
            $display("FAIL %s: got state=%0d ctl=%h ill=%b, want state=%0d ctl=%h ill=%b",
                     nm, state, ctl_s, illegalOp, es, ec, ei);
        end
    endtask

    // Drive one cycle's inputs, check mid-cycle, then advance past the edge.
    task automatic apply(input vec_t v, input string nm);
        opcode   = v.op;
        memReady = v.rdy;
        @(negedge clk);
        check(nm, v.st, v.ctl, v.ill);
        @(posedge clk);
        #1;
    endtask

    // Reference: expected controls for a phase (spec state code) and memReady.
    function automatic logic [15:0] phase_ctl(logic [3:0] code, logic rdy);
        case (code)
            4'd1:    return rdy ? C_F1 : C_F0;
            4'd2:    return C_DEC;
            4'd3:    return C_MA;
            4'd4:    return C_MR;
            4'd5:    return C_MWB;
            4'd6:    return C_MW;
            4'd7:    return C_RT;
            4'd8:    return C_AWB;
            4'd9:    return C_BEQ;
            4'd10:   return C_J;
            4'd11:   return C_MA;
            4'd12:   return C_AIWB;
            default: return C_ZERO;
        endcase
    endfunction

    task automatic emit(input logic [5:0] op, input logic [3:0] code, input logic rdy);
        apply(mk(op, rdy, code, phase_ctl(code, rdy), m_ill), "rand");
    endtask

    // A memory phase: a random number of stall cycles, then the ready cycle.
    task automatic emit_wait(input logic [5:0] op, input logic [3:0] code);
        int k;
        k = $urandom_range(0, 2);
        for (int i = 0; i < k; i++) emit(op, code, 1'b0);
        emit(op, code, 1'b1);
    endtask

    // One instruction as the list of phases the specification gives for it.
    task automatic run_instr(input logic [5:0] op);
        emit_wait(op, 4'd1);
        emit(op, 4'd2, 1'($urandom));
        case (op)
            LW: begin
                emit(op, 4'd3, 1'($urandom));
                emit_wait(op, 4'd4);
                emit(op, 4'd5, 1'($urandom));
            end
            SW: begin
                emit(op, 4'd3, 1'($urandom));
                emit_wait(op, 4'd6);
            end
            RT: begin emit(op, 4'd7, 1'($urandom)); emit(op, 4'd8, 1'($urandom)); end
            BQ: emit(op, 4'd9, 1'($urandom));
            JJ: emit(op, 4'd10, 1'($urandom));
            AI: begin emit(op, 4'd11, 1'($urandom)); emit(op, 4'd12, 1'($urandom)); end
            default: m_ill = 1'b1;
        endcase
    endtask

    initial begin
        logic [5:0] legal [6];
        logic [5:0] op;
        legal[0] = LW; legal[1] = SW; legal[2] = RT;
        legal[3] = BQ; legal[4] = JJ; legal[5] = AI;

        // Held in reset with a lw opcode present
        opcode = LW; memReady = 1'b1; rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("reset_hold", 4'd0, C_ZERO, 1'b0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed table: reset release, then one of each instruction class
        tbl.push_back(mk(LW, 1'b1, 4'd0, C_ZERO, 1'b0));
        tbl.push_back(mk(LW, 1'b1, 4'd1, C_F1,   1'b0));
        tbl.push_back(mk(LW, 1'b1, 4'd2, C_DEC,  1'b0));
        tbl.push_back(mk(LW, 1'b1, 4'd3, C_MA,   1'b0));
        tbl.push_back(mk(LW, 1'b1, 4'd4, C_MR,   1'b0));
        tbl.push_back(mk(LW, 1'b1, 4'd5, C_MWB,  1'b0));
        tbl.push_back(mk(SW, 1'b1, 4'd1, C_F1,   1'b0));
        tbl.push_back(mk(SW, 1'b1, 4'd2, C_DEC,  1'b0));
        tbl.push_back(mk(SW, 1'b1, 4'd3, C_MA,   1'b0));
        tbl.push_back(mk(SW, 1'b0, 4'd6, C_MW,   1'b0));
        tbl.push_back(mk(SW, 1'b0, 4'd6, C_MW,   1'b0));
        tbl.push_back(mk(SW, 1'b0, 4'd6, C_MW,   1'b0));
        tbl.push_back(mk(SW, 1'b1, 4'd6, C_MW,   1'b0));
        tbl.push_back(mk(RT, 1'b1, 4'd1, C_F1,   1'b0));
        tbl.push_back(mk(RT, 1'b1, 4'd2, C_DEC,  1'b0));
        tbl.push_back(mk(RT, 1'b1, 4'd7, C_RT,   1'b0));
        tbl.push_back(mk(RT, 1'b1, 4'd8, C_AWB,  1'b0));
        tbl.push_back(mk(BQ, 1'b1, 4'd1, C_F1,   1'b0));
        tbl.push_back(mk(BQ, 1'b1, 4'd2, C_DEC,  1'b0));
        tbl.push_back(mk(BQ, 1'b1, 4'd9, C_BEQ,  1'b0));
        tbl.push_back(mk(JJ, 1'b1, 4'd1, C_F1,   1'b0));
        tbl.push_back(mk(JJ, 1'b1, 4'd2, C_DEC,  1'b0));
        tbl.push_back(mk(JJ, 1'b1, 4'd10, C_J,   1'b0));
        tbl.push_back(mk(AI, 1'b1, 4'd1, C_F1,   1'b0));
        tbl.push_back(mk(AI, 1'b1, 4'd2, C_DEC,  1'b0));
        tbl.push_back(mk(AI, 1'b1, 4'd11, C_MA,  1'b0));
        tbl.push_back(mk(AI, 1'b1, 4'd12, C_AIWB, 1'b0));
        tbl.push_back(mk(BAD, 1'b1, 4'd1, C_F1,  1'b0));
        tbl.push_back(mk(BAD, 1'b1, 4'd2, C_DEC, 1'b0));
        tbl.push_back(mk(LW, 1'b1, 4'd1, C_F1,   1'b1));
        tbl.push_back(mk(LW, 1'b1, 4'd2, C_DEC,  1'b1));
        tbl.push_back(mk(LW, 1'b1, 4'd3, C_MA,   1'b1));
        tbl.push_back(mk(LW, 1'b1, 4'd4, C_MR,   1'b1));
        tbl.push_back(mk(LW, 1'b1, 4'd5, C_MWB,  1'b1));
        foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d", i));

        // Fetch stall: strobes stay low while memReady=0, then pulse once
        apply(mk(JJ, 1'b0, 4'd1, C_F0,  1'b1), "fetch_stall0");
        apply(mk(JJ, 1'b0, 4'd1, C_F0,  1'b1), "fetch_stall1");
        apply(mk(JJ, 1'b1, 4'd1, C_F1,  1'b1), "fetch_ready");
        apply(mk(JJ, 1'b1, 4'd2, C_DEC, 1'b1), "fetch_next");
        apply(mk(JJ, 1'b1, 4'd10, C_J,  1'b1), "fetch_jump");

        // Asynchronous reset in the middle of a stalled MEMRD
        apply(mk(LW, 1'b1, 4'd1, C_F1,  1'b1), "abort_f");
        apply(mk(LW, 1'b1, 4'd2, C_DEC, 1'b1), "abort_d");
        apply(mk(LW, 1'b1, 4'd3, C_MA,  1'b1), "abort_ma");
        opcode = LW; memReady = 1'b0;
        @(negedge clk);
        check("abort_memrd", 4'd4, C_MR, 1'b1);
        #2 rst_n = 1'b0;
        #1 check("abort_async", 4'd0, C_ZERO, 1'b0);
        @(posedge clk); #1;
        check("abort_held", 4'd0, C_ZERO, 1'b0);
        rst_n = 1'b1;
        m_ill = 1'b0;

        // Randomized instruction stream against the phase-list model
        emit(LW, 4'd0, 1'b1);
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) < 6) op = legal[$urandom_range(0, 5)];
            else op = 6'($urandom);
            run_instr(op);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/main_control_fsm.md
Name: main_control_fsm

Overview:
- Multi-cycle main control unit. It decodes the instruction opcode and sequences datapath control one state per clock.
- It is the producer of the aluOp interface that ALU_Control consumes:
  - aluOp 00 = add (address, PC+4)
  - aluOp 01 = subtract (beq compare)
  - aluOp 10 = R-type, decode func
- It sits between the instruction register and the datapath muxes, register-file and memory enables.
- Memory accesses are stretched with a memReady handshake.

Parameters:
- ADDI_EN, 1, when 1 opcode 001000 (addi) is decoded; when 0 it is treated as illegal.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- opcode  input  6  instruction[31:26] from the instruction register
- memReady  input  1  memory completes the current access this cycle
- pcWrite  output  1  unconditional PC load
- pcWriteCond  output  1  PC load if ALU zero
- iorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- memRead  output  1  memory read request
- memWrite  output  1  memory write request
- irWrite  output  1  instruction register load
- memToReg  output  1  register write data: 0 = ALUOut, 1 = MDR
- regDst  output  1  destination: 0 = rt, 1 = rd
- regWrite  output  1  register file write
- aluSrcA  output  1  0 = PC, 1 = rs
- aluSrcB  output  2  00 = rt, 01 = const 4, 10 = signext imm, 11 = signext imm<<2
- aluOp  output  2  to ALU_Control, encoding as in Overview
- pcSource  output  2  00 = ALU, 01 = ALUOut, 10 = jump target
- illegalOp  output  1  sticky: unsupported opcode seen in DECODE
- state  output  4  current state, for debug and verification

Behaviour:
- State register plus next-state logic. Outputs decode combinationally from state (Moore). The only Mealy terms are memReady-gated strobes, noted below.
- Reset (rst_n=0, async): state=IDLE, illegalOp=0. Every control output is 0 in IDLE, including aluOp=00 and pcSource=00.
- Reset mid-instruction aborts immediately. No write strobe may be asserted while rst_n=0.
- State encoding and transitions. Any output not listed is 0.
  - IDLE(0) -> FETCH unconditionally.
  - FETCH(1):
    - Outputs: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=00.
    - irWrite=memReady, pcWrite=memReady.
    - Stays in FETCH while memReady=0; -> DECODE when memReady=1.
  - DECODE(2):
    - Outputs: aluSrcA=0, aluSrcB=11, aluOp=00 (precompute branch target).
    - Opcode dispatch:
      - 100011 or 101011 -> MEMADR
      - 000000 -> RTYPE
      - 000100 -> BEQ
      - 000010 -> JUMP
      - 001000 -> ADDIEX (when ADDI_EN=1)
      - any other opcode -> FETCH and set illegalOp=1.
  - MEMADR(3):
    - Outputs: aluSrcA=1, aluSrcB=10, aluOp=00.
    - -> MEMRD if opcode=100011, else MEMWR.
  - MEMRD(4):
    - Outputs: memRead=1, iorD=1.
    - Stays while memReady=0; -> MEMWB when memReady=1.
  - MEMWB(5):
    - Outputs: regWrite=1, memToReg=1, regDst=0.
    - -> FETCH.
  - MEMWR(6):
    - Outputs: memWrite=1, iorD=1.
    - Stays while memReady=0; -> FETCH when memReady=1.
    - memWrite stays asserted through all wait cycles.
  - RTYPE(7): aluSrcA=1, aluSrcB=00, aluOp=10. -> ALUWB.
  - ALUWB(8): regWrite=1, regDst=1, memToReg=0. -> FETCH.
  - BEQ(9): aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=01. -> FETCH.
  - JUMP(10): pcWrite=1, pcSource=10. -> FETCH.
  - ADDIEX(11): aluSrcA=1, aluSrcB=10, aluOp=00. -> ADDIWB.
  - ADDIWB(12): regWrite=1, regDst=0, memToReg=0. -> FETCH.
  - Codes 13-15 are unreachable; if entered -> FETCH, all outputs 0.
- Timing: opcode is sampled only in DECODE and MEMADR. The IR is stable there because it is loaded only in FETCH.
- Cycle counts with memReady tied to 1:
  - lw = 5
  - sw = 4
  - R-type = 4
  - addi = 4
  - beq = 3
  - j = 3
  - Each memReady=0 cycle adds one cycle.
- illegalOp clears only on reset.
- memRead and memWrite are never asserted in the same cycle.

Test Plan:
- Reset release:
  - Hold rst_n=0 with opcode=100011 -> state=0, all outputs 0.
  - Release -> state sequence 0,1,2.
  - Assert rst_n=0 asynchronously mid-MEMRD -> state=0 with no clock edge.
- lw with memReady=1:
  - State sequence 1,2,3,4,5,1.
  - aluOp: 00 in FETCH, DECODE, MEMADR.
  - MEMWB: regWrite=1, memToReg=1.
  - Total 5 cycles.
- sw with memReady low for 3 cycles in MEMWR -> memWrite=1 for 4 consecutive cycles, then FETCH, and regWrite never asserts.
- R-type (opcode 000000):
  - RTYPE: aluOp=10, aluSrcB=00.
  - ALUWB: regDst=1, regWrite=1.
- beq (000100): BEQ has aluOp=01, pcWriteCond=1, pcSource=01.
- j (000010) -> JUMP: pcWrite=1, pcSource=10.
- Illegal opcode 111111 -> DECODE goes to FETCH, illegalOp=1 and stays 1 through a following lw.
- Fetch stall: memReady=0 for 2 cycles in FETCH -> irWrite=0 and pcWrite=0 while memReady=0, then irWrite=1 and pcWrite=1 for exactly one cycle.
